// File: rtl/vga_capture_pkg.sv
// Shared types and default timing for the VGA frame capture path.
//   - cap_state_e : capture FSM states
//   - pixel_t     : 12-bit {r,g,b} pixel, 4 bits per channel
//   - *_DEF       : default 640x480 timing (active, back porch, vertical skip)
package vga_capture_pkg;

  localparam int unsigned CAP_WIDTH  = 320;
  localparam int unsigned CAP_HEIGHT = 240;

  localparam int unsigned H_ACTIVE_DEF = 2 * CAP_WIDTH;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 2 * CAP_HEIGHT;
  localparam int unsigned V_SKIP_DEF   = 33;

  // Shared pixel/back-porch/skip counter and line counter widths.
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned LINE_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    V_SKIP_ST,
    H_BACK,
    PIXELS,
    LINE_WAIT,
    DONE
  } cap_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Input stage of the capture path: registers the raw VGA inputs once and
// produces rise/fall strobes for hsync and vsync by comparing the registered
// value with its previous value.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   hsync_i, vsync_i      raw active-low syncs
//   red_i/green_i/blue_i  raw colour samples
//   pix_o                 registered pixel {r,g,b}
//   hs_rise_o/hs_fall_o   registered hsync edge strobes
//   vs_rise_o/vs_fall_o   registered vsync edge strobes
module vga_sync_edge_detect
  import vga_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [3:0] red_i,
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  output pixel_t     pix_o,
  output logic       hs_rise_o,
  output logic       hs_fall_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o
);

  logic   hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic   vs_q, vs_d, vs_prev_q, vs_prev_d;
  pixel_t pix_q, pix_d;

  always_comb begin
    hs_d      = hsync_i;
    vs_d      = vsync_i;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    pix_d.r   = red_i;
    pix_d.g   = green_i;
    pix_d.b   = blue_i;
  end

  // Syncs reset to their idle (high) level so no edge is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      pix_q     <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      pix_q     <= pix_d;
    end
  end

  assign pix_o     = pix_q;
  assign hs_rise_o = hs_q & ~hs_prev_q;
  assign hs_fall_o = ~hs_q & hs_prev_q;
  assign vs_rise_o = vs_q & ~vs_prev_q;
  assign vs_fall_o = ~vs_q & vs_prev_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures a VGA stream, decimates 2x in each axis and writes the result
// sequentially into the frame SRAM write port.
// Build option: VGA_CAPTURE_CONTINUOUS_EN -- when defined, every frame is
// captured after a single start (DONE re-arms instead of going idle).
// Ports:
//   clk, rst_n                     pixel clock, async active-low reset
//   start                          arm capture of the next frame (IDLE only)
//   vga_hsync, vga_vsync           active-low syncs
//   vga_red/green/blue             4-bit colour samples
//   sram_we, sram_addr, sram_din   registered SRAM write port
//   busy                           capture armed or in progress
//   frame_done                     one-cycle pulse at frame end
//   sync_error                     sticky abort flag, cleared on arming
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_SKIP     = V_SKIP_DEF,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  vga_hsync,
  input  logic                  vga_vsync,
  input  logic [3:0]            vga_red,
  input  logic [3:0]            vga_green,
  input  logic [3:0]            vga_blue,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sync_error
);

  pixel_t pix;
  logic   hs_rise, hs_fall, vs_rise, vs_fall;

  vga_sync_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync_i   (vga_hsync),
    .vsync_i   (vga_vsync),
    .red_i     (vga_red),
    .green_i   (vga_green),
    .blue_i    (vga_blue),
    .pix_o     (pix),
    .hs_rise_o (hs_rise),
    .hs_fall_o (hs_fall),
    .vs_rise_o (vs_rise),
    .vs_fall_o (vs_fall)
  );

  cap_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  sync_error_q, sync_error_d;
  logic                  arm;
  logic                  err;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    wr_addr_d    = wr_addr_q;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_din_d   = sram_din_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    sync_error_d = sync_error_q;
    arm          = 1'b0;

    // cnt_q in PIXELS is the pixel index k of the pixel held in the input
    // register this cycle; the write lands on the port next cycle. This also
    // runs in an abort cycle so the in-flight pixel still completes.
    if (state_q == PIXELS && !line_q[0] && !cnt_q[0]) begin
      sram_we_d   = 1'b1;
      sram_addr_d = wr_addr_q;
      sram_din_d  = DATA_WIDTH'(pix);
      wr_addr_d   = wr_addr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) arm = 1'b1;
      end
      ARMED: begin
        if (vs_rise) begin
          state_d = V_SKIP_ST;
          cnt_d   = '0;
        end
      end
      V_SKIP_ST: begin
        if (hs_rise) begin
          if (cnt_q == CNT_W'(V_SKIP)) begin
            state_d = H_BACK;
            cnt_d   = CNT_W'(1);
            line_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // The hsync rise cycle counts as back-porch clock 0, so H_BACK itself
      // spans H_BP-1 cycles and PIXELS starts exactly H_BP after the rise.
      H_BACK: begin
        if (cnt_q == CNT_W'(H_BP - 1)) begin
          state_d = PIXELS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PIXELS: begin
        if (cnt_q == CNT_W'(H_ACTIVE - 1)) begin
          if (line_q == LINE_W'(V_ACTIVE - 1)) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
`ifndef VGA_CAPTURE_CONTINUOUS_EN
            busy_d       = 1'b0;
`endif
          end else begin
            state_d = LINE_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LINE_WAIT: begin
        if (hs_rise) begin
          state_d = H_BACK;
          cnt_d   = CNT_W'(1);
          line_d  = line_q + 1'b1;
        end
      end
      DONE: begin
`ifdef VGA_CAPTURE_CONTINUOUS_EN
        arm = 1'b1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (arm) begin
      state_d      = ARMED;
      sync_error_d = 1'b0;
      busy_d       = 1'b1;
      wr_addr_d    = '0;
    end

    err = (hs_fall && (state_q == H_BACK || state_q == PIXELS)) ||
          (vs_fall && (state_q == V_SKIP_ST || state_q == H_BACK ||
                       state_q == PIXELS || state_q == LINE_WAIT));
    if (err) begin
      state_d      = IDLE;
      sync_error_d = 1'b1;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      wr_addr_q    <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      wr_addr_q    <= wr_addr_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_din   = sram_din_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture with a shrunk raster (32x8 active, 4-clock
// back porch, 3 skipped lines) so whole frames stay short.
module tb_vga_frame_capture;

  localparam int H_ACT    = 32;
  localparam int HBP      = 4;
  localparam int V_ACT    = 8;
  localparam int VSK      = 3;
  localparam int HS_W     = 4;
  localparam int H_FP     = 4;
  localparam int AW       = 17;
  localparam int DW       = 12;
  localparam int LINE_LEN = HS_W + HBP + H_ACT + H_FP;
  localparam int WPF      = (H_ACT / 2) * (V_ACT / 2);  // 64 writes per frame

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hs = 1'b1;
  logic          vs = 1'b1;
  logic [3:0]    r = '0, g = '0, b = '0;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          busy, frame_done, sync_error;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_ACTIVE   (H_ACT),
    .H_BP       (HBP),
    .V_ACTIVE   (V_ACT),
    .V_SKIP     (VSK),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vga_hsync  (hs),
    .vga_vsync  (vs),
    .vga_red    (r),
    .vga_green  (g),
    .vga_blue   (b),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_error (sync_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: captures memory image and write statistics.
  logic [11:0]   mem [0:WPF-1];
  int            wr_cnt = 0, done_cnt = 0, zero_cnt = 0, contig_err = 0, busy_done_err = 0;
  int            last_wr_cyc = 0, zero_wr_cyc = 0;
  logic [AW-1:0] exp_addr = '0;

  always @(negedge clk) begin
    if (sram_we === 1'b1) begin
      if (sram_addr == '0) begin
        zero_cnt    = zero_cnt + 1;
        zero_wr_cyc = cyc;
      end else if (sram_addr != exp_addr) begin
        contig_err = contig_err + 1;
      end
      if (int'(sram_addr) < WPF) mem[sram_addr[5:0]] = sram_din;
      else contig_err = contig_err + 1;
      exp_addr    = sram_addr + 1'b1;
      last_wr_cyc = cyc;
      wr_cnt      = wr_cnt + 1;
    end
    if (frame_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (busy !== 1'b0) busy_done_err = busy_done_err + 1;
    end
  end

  int checks = 0, passed = 0;
  int b_wr, b_done, b_zero, b_contig;
  int abort_cyc = 0, pix00_cyc = 0;

  typedef struct {
    int          x;
    int          y;
    int          addr;
    logic [11:0] data;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},         {31'd0, sram_we},    0);
    chk({tag, "_addr"},       {15'd0, sram_addr},  0);
    chk({tag, "_din"},        {20'd0, sram_din},   0);
    chk({tag, "_busy"},       {31'd0, busy},       0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_sync_error"}, {31'd0, sync_error}, 0);
  endtask

  task automatic snap;
    b_wr = wr_cnt; b_done = done_cnt; b_zero = zero_cnt; b_contig = contig_err;
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    logic [7:0] xx, yy;
    xx = x[7:0];
    yy = y[7:0];
    return {xx[3:0], yy[3:0], xx[7:4]};
  endfunction

  task automatic drive(input logic h, input logic v, input logic [11:0] p, input logic s);
    @(negedge clk);
    hs = h; vs = v; {r, g, b} = p; start = s;
  endtask

  task automatic pulse_start;
    drive(hs, vs, {r, g, b}, 1'b1);
    drive(hs, vs, {r, g, b}, 1'b0);
  endtask

  task automatic blank_line(input logic v);
    for (int j = 0; j < LINE_LEN; j++) drive(j >= HS_W, v, 12'h000, 1'b0);
  endtask

  // mode 0: normal; 1: hsync falls at (ab_x,ab_y); 2: reset at (ab_x,ab_y).
  // st_y: active line on which a start pulse is injected (-1 for none).
  task automatic frame(input int mode, input int ab_y, input int ab_x, input bit abc, input int st_y);
    blank_line(1'b0);
    blank_line(1'b0);
    for (int i = 0; i < VSK; i++) blank_line(1'b1);
    for (int y = 0; y < V_ACT; y++) begin
      for (int j = 0; j < HS_W; j++) drive(1'b0, 1'b1, 12'h000, 1'b0);
      for (int j = 0; j < HBP; j++) drive(1'b1, 1'b1, 12'h000, 1'b0);
      for (int x = 0; x < H_ACT; x++) begin
        if (mode == 1 && y == ab_y && x == ab_x) begin
          drive(1'b0, 1'b1, pix(x, y), 1'b0);
          abort_cyc = cyc;
          for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, 12'h000, 1'b0);
          return;
        end
        if (mode == 2 && y == ab_y && x == ab_x) begin
          @(negedge clk);
          rst_n = 1'b0;
          #1;
          chk_all_zero("midline_reset");
          return;
        end
        drive(1'b1, 1'b1, (abc && x == 0 && y == 0) ? 12'hABC : pix(x, y), (y == st_y && x == 5));
        if (x == 0 && y == 0) pix00_cyc = cyc;
      end
      for (int j = 0; j < H_FP; j++) drive(1'b1, 1'b1, 12'h000, 1'b0);
    end
    blank_line(1'b1);
    blank_line(1'b1);
  endtask

  task automatic check_table;
    for (int i = 0; i < 8; i++)
      chk($sformatf("mem_x%0d_y%0d", tbl[i].x, tbl[i].y),
          {20'd0, mem[tbl[i].addr]}, {20'd0, tbl[i].data});
  endtask

  initial begin
    tbl[0] = '{x: 0,  y: 0, addr: 0,  data: 12'h000};
    tbl[1] = '{x: 2,  y: 0, addr: 1,  data: 12'h200};
    tbl[2] = '{x: 30, y: 0, addr: 15, data: 12'hE01};
    tbl[3] = '{x: 0,  y: 2, addr: 16, data: 12'h020};
    tbl[4] = '{x: 2,  y: 2, addr: 17, data: 12'h220};
    tbl[5] = '{x: 18, y: 2, addr: 25, data: 12'h221};
    tbl[6] = '{x: 16, y: 4, addr: 40, data: 12'h041};
    tbl[7] = '{x: 30, y: 6, addr: 63, data: 12'hE61};
    for (int i = 0; i < WPF; i++) mem[i] = 12'hFFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 12'h000, 1'b0);

`ifdef VGA_CAPTURE_CONTINUOUS_EN
    // One start, two back-to-back frames.
    snap;
    pulse_start;
    frame(0, 0, 0, 1'b0, -1);
    frame(0, 0, 0, 1'b0, -1);
    chk("cont_writes",      wr_cnt - b_wr,         2 * WPF);
    chk("cont_frame_done",  done_cnt - b_done,     2);
    chk("cont_addr0_count", zero_cnt - b_zero,     2);
    chk("cont_contiguous",  contig_err - b_contig, 0);
    chk("cont_busy",        {31'd0, busy},         1);
    chk("cont_sync_error",  {31'd0, sync_error},   0);
    check_table;
`else
    // Sync activity without start: nothing written.
    snap;
    frame(0, 0, 0, 1'b0, -1);
    chk("nostart_writes",     wr_cnt - b_wr,     0);
    chk("nostart_busy",       {31'd0, busy},     0);
    chk("nostart_frame_done", done_cnt - b_done, 0);

    // Full frame, with a start pulse mid-frame that must be ignored.
    snap;
    pulse_start;
    chk("start_busy", {31'd0, busy}, 1);
    frame(0, 0, 0, 1'b0, 3);
    chk("frame_writes",      wr_cnt - b_wr,         WPF);
    chk("frame_done_count",  done_cnt - b_done,     1);
    chk("frame_addr0_count", zero_cnt - b_zero,     1);
    chk("frame_contiguous",  contig_err - b_contig, 0);
    chk("busy_at_done",      busy_done_err,         0);
    chk("frame_end_busy",    {31'd0, busy},         0);
    chk("frame_sync_error",  {31'd0, sync_error},   0);
    check_table;

    // hsync falls at pixel 10 of active line 4.
    snap;
    pulse_start;
    frame(1, 4, 10, 1'b0, -1);
    chk("abort_sync_error", {31'd0, sync_error}, 1);
    chk("abort_busy",       {31'd0, busy},       0);
    chk("abort_frame_done", done_cnt - b_done,   0);
    chk_range("abort_writes",     wr_cnt - b_wr,           37, 38);
    chk_range("abort_last_write", last_wr_cyc - abort_cyc, 0,  2);
    snap;
    frame(0, 0, 0, 1'b0, -1);
    chk("post_abort_writes", wr_cnt - b_wr, 0);

    // Re-arm clears the error; reset mid-line; then a clean capture.
    pulse_start;
    chk("rearm_sync_error", {31'd0, sync_error}, 0);
    chk("rearm_busy",       {31'd0, busy},       1);
    frame(2, 5, 12, 1'b0, -1);
    repeat (2) drive(1'b1, 1'b1, 12'h000, 1'b0);
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 12'h000, 1'b0);
    snap;
    pulse_start;
    frame(0, 0, 0, 1'b1, -1);
    chk("clean_writes",      wr_cnt - b_wr,     WPF);
    chk("clean_addr0_count", zero_cnt - b_zero, 1);
    chk("clean_frame_done",  done_cnt - b_done, 1);
    chk("latency_cycles",    zero_wr_cyc - pix00_cyc, 2);
    chk("latency_data",      {20'd0, mem[0]},   32'hABC);
    chk("clean_x2_y2",       {20'd0, mem[17]},  32'h220);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
